// File: rtl/fib_stack.sv
// Frame stack for the recursive Fibonacci datapath: responds to single-cycle
// push/pop requests from the controller and pulses readySig on completion.
module fib_stack #(
    parameter int W     = 24,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          pushSig,
    input  logic          popSig,
    input  logic [W-1:0]  push_data,
    input  logic          clr_err,
    output logic [W-1:0]  pop_data,
    output logic          readySig,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow,
    output logic          collision
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   sp_reg;
    logic [W-1:0]    frame_reg;
    logic [W-1:0]    pop_data_reg;
    logic            overflow_reg, underflow_reg, collision_reg;
    logic [W-1:0]    mem [DEPTH];

    logic            is_full, is_empty;
    logic            capture, do_write, do_read;
    logic            set_overflow, set_underflow, set_collision;
    logic            ready;
    logic [AW-1:0]   wr_addr, rd_addr;

    assign is_full  = (sp_reg == CW'(DEPTH));
    assign is_empty = (sp_reg == '0);
    assign wr_addr  = sp_reg[AW-1:0];
    // When sp == DEPTH the low bits wrap to 0, so subtracting 1 lands on the top slot.
    assign rd_addr  = sp_reg[AW-1:0] - AW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        capture       = 1'b0;
        do_write      = 1'b0;
        do_read       = 1'b0;
        set_overflow  = 1'b0;
        set_underflow = 1'b0;
        set_collision = 1'b0;
        ready         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pushSig) begin
                    state_next    = PUSH;
                    capture       = 1'b1;
                    set_collision = popSig;
                end else if (popSig) begin
                    state_next = POP;
                end
            end
            PUSH: begin
                state_next = DONE;
                if (is_full) begin
                    set_overflow = 1'b1;
                end else begin
                    do_write = 1'b1;
                end
            end
            POP: begin
                state_next = DONE;
                if (is_empty) begin
                    set_underflow = 1'b1;
                end else begin
                    do_read = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                ready      = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame storage carries no reset so it can map onto a register-file RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_addr] <= frame_reg;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp_reg        <= '0;
            frame_reg     <= '0;
            pop_data_reg  <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            collision_reg <= 1'b0;
        end else begin
            if (capture) begin
                frame_reg <= push_data;
            end
            if (do_write) begin
                sp_reg <= sp_reg + CW'(1);
            end else if (do_read) begin
                sp_reg       <= sp_reg - CW'(1);
                pop_data_reg <= mem[rd_addr];
            end
            // A new error event outranks a simultaneous clear.
            if (set_overflow) begin
                overflow_reg <= 1'b1;
            end else if (clr_err) begin
                overflow_reg <= 1'b0;
            end
            if (set_underflow) begin
                underflow_reg <= 1'b1;
            end else if (clr_err) begin
                underflow_reg <= 1'b0;
            end
            if (set_collision) begin
                collision_reg <= 1'b1;
            end else if (clr_err) begin
                collision_reg <= 1'b0;
            end
        end
    end

    assign readySig  = ready;
    assign pop_data  = pop_data_reg;
    assign count     = sp_reg;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign collision = collision_reg;

endmodule

// File: doc/fib_stack.md
# fib_stack

Frame stack for the recursive Fibonacci datapath. It is the responder side of the controller's stack handshake: it accepts single-cycle `pushSig`/`popSig` requests, stores or returns one packed call frame, and signals completion with `readySig`. It sits between the Fibonacci `Controller` and a register-file memory of `DEPTH` frames, with overflow and underflow bookkeeping.

## Interface
- `W`, default 24: frame width; packed as {n[7:0], flag[7:0], ret[7:0]}.
- `DEPTH`, default 16: number of frames; must be a power of two, at least 2.
- `CW`, default $clog2(DEPTH+1): width of the occupancy count.

- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `pushSig`  in  1  push request; sampled only in IDLE.
- `popSig`  in  1  pop request; sampled only in IDLE.
- `push_data`  in  W  frame to push; sampled with `pushSig`.
- `clr_err`  in  1  synchronous clear of the sticky error flags.
- `pop_data`  out  W  last popped frame; registered, and held until the next successful pop.
- `readySig`  out  1  one-cycle completion pulse for every accepted request.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `count`  out  CW  number of frames stored.
- `overflow`  out  1  sticky: a push was attempted while full.
- `underflow`  out  1  sticky: a pop was attempted while empty.
- `collision`  out  1  sticky: `pushSig` and `popSig` were high together in IDLE.

## Operation
- State machine: IDLE, PUSH, POP, DONE. The state register is 2 bits.
- IDLE transitions:
  - `pushSig`=1 → PUSH. Push has priority over pop.
  - `popSig`=1 and `pushSig`=0 → POP.
  - Otherwise stay in IDLE.
- Sampling in IDLE:
  - `push_data` is captured into a frame register on request acceptance.
  - If both requests are high, `collision` is set and the pop is dropped.
- PUSH:
  - If not full: mem[sp] ← frame, then sp ← sp+1.
  - If full: no write, sp unchanged, `overflow` ← 1.
  - Next state is always DONE.
- POP:
  - If not empty: sp ← sp−1, and `pop_data` ← mem[sp−1].
  - If empty: sp unchanged, `pop_data` unchanged, `underflow` ← 1.
  - Next state is always DONE.
- DONE: `readySig`=1 for this cycle only, then → IDLE.
- Requests seen in PUSH, POP or DONE are ignored and are not queued. The controller must wait for `readySig` before issuing another request.
- Stack pointer and count:
  - sp has CW bits and ranges 0..DEPTH.
  - Memory is indexed with sp[$clog2(DEPTH)-1:0].
  - `count` = sp, so `full`/`empty` are derived combinationally from sp.
- Sticky flags:
  - `clr_err`=1 clears all three flags at the next edge.
  - If a new error event occurs in the same cycle as `clr_err`, the set wins.
- Memory is not reset. Its contents are don't-care until written.

## Timing
- Reset (`rstn`=0, asynchronous): state=IDLE, sp=0, `pop_data`=0, `readySig`=0, `overflow`=`underflow`=`collision`=0. This gives `empty`=1, `full`=0, `count`=0.
- Deasserting reset mid-operation: the aborted request produces no `readySig` and no memory side effects are guaranteed.
- Latency: request high at edge k (in IDLE) → PUSH/POP active in cycle k+1 → `readySig` high in cycle k+2.
- New values of `count`, `full`, `empty` and `pop_data` are all visible when `readySig` is high.
- Minimum request spacing is 3 cycles. A request held high continuously is re-accepted in the IDLE cycle after DONE.
- Error requests (push when full, pop when empty) still produce exactly one `readySig` pulse, with the same 2-cycle latency.

## Test plan
- Reset, then push 0x050100 → `readySig` at cycle +2, `count`=1, `empty`=0. Then pop → `pop_data`=0x050100, `count`=0, `empty`=1.
- Push 0x000001..0x000010 (16 frames) → `full`=1. Then pop 16 times → data returned 0x000010 down to 0x000001 (LIFO), `empty`=1, no error flags set.
- With the stack full, push 0xAAAAAA → `readySig` pulses, `overflow`=1, `count`=16. The next pop returns 0x000010.
- Pop with the stack empty → `readySig` pulses, `underflow`=1, `pop_data` unchanged. Then `clr_err`=1 → `underflow`=0 on the next edge.
- In IDLE with 1 frame stored, drive `pushSig`=`popSig`=1 with 0x123456 → `collision`=1, `count`=2. Also re-pulse `pushSig` during PUSH → it is ignored and `count` remains 2.
- Assert `rstn`=0 while in POP with 3 frames stored → all outputs go to their reset values immediately, and no `readySig` pulse follows.
